// File: rtl/u_rec_frame.sv
// 8N1 UART receiver: oversampled start detection, 3-sample majority voting per bit cell,
// and a ready/ack byte handshake with framing-error and overrun status.
module u_rec_frame #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_recH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  input  logic       rec_ackH,
  output logic       frame_errH,
  output logic       overrunH,
  output logic       rec_busyH
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned Mid  = OVERSAMPLE / 2;

  localparam logic [CntW-1:0] CntLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntSampA = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntSampB = CntW'(Mid);
  localparam logic [CntW-1:0] CntDecide = CntW'(Mid + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} recState_e;

  recState_e             state;
  logic [SYNC_STAGES-1:0] syncFf;
  logic [CntW-1:0]       cellCnt;
  logic [3:0]            bitCnt;
  logic [7:0]            shiftReg;
  logic [1:0]            samp;
  logic                  prevRx;
  logic                  armed;
  logic                  rxS;
  logic                  cellWrap;
  logic                  decide;
  logic                  majority;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      syncFf <= '1;
    end else begin
      syncFf <= {syncFf[SYNC_STAGES-2:0], uart_recH};
    end
  end

  always_comb begin
    rxS       = syncFf[SYNC_STAGES-1];
    cellWrap  = (cellCnt == CntLast);
    decide    = (cellCnt == CntDecide);
    majority  = (samp[0] & samp[1]) | (samp[0] & rxS) | (samp[1] & rxS);
    rec_busyH = (state != R_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= R_IDLE;
      cellCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      samp       <= '0;
      prevRx     <= 1'b1;
      armed      <= 1'b0;
      rec_dataH  <= '0;
      rec_readyH <= 1'b0;
      frame_errH <= 1'b0;
      overrunH   <= 1'b0;
    end else begin
      prevRx <= rxS;
      if (rec_readyH && rec_ackH) begin
        rec_readyH <= 1'b0;
        overrunH   <= 1'b0;
      end
      if (cellCnt == CntSampA) samp[0] <= rxS;
      if (cellCnt == CntSampB) samp[1] <= rxS;

      unique case (state)
        R_IDLE: begin
          cellCnt <= '0;
          if (rxS) armed <= 1'b1;
          // Detect cycle is cell count 0, so the following cycle is count 1.
          if (armed && prevRx && !rxS) begin
            state   <= R_START;
            cellCnt <= CntW'(1);
          end
        end
        R_START: begin
          cellCnt <= cellWrap ? '0 : cellCnt + 1'b1;
          if (decide && majority) begin
            state   <= R_IDLE;
            cellCnt <= '0;
          end else if (cellWrap) begin
            state  <= R_DATA;
            bitCnt <= '0;
          end
        end
        R_DATA: begin
          cellCnt <= cellWrap ? '0 : cellCnt + 1'b1;
          if (decide) begin
            shiftReg <= {majority, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
          end
          if (cellWrap && bitCnt == 4'd8) begin
            state  <= R_STOP;
            bitCnt <= '0;
          end
        end
        R_STOP: begin
          cellCnt <= cellWrap ? '0 : cellCnt + 1'b1;
          // Leave at the decision point so a back-to-back start edge is not missed.
          if (decide) begin
            rec_dataH  <= shiftReg;
            frame_errH <= ~majority;
            rec_readyH <= 1'b1;
            if (rec_readyH && !rec_ackH) overrunH <= 1'b1;
            state   <= R_IDLE;
            cellCnt <= '0;
            armed   <= 1'b0;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule
